// File: rtl/drc_frame_capture_fsm_if.sv
// Pixel-FIFO side and DMA byte-stream side of the DVP capture block.
// master: the FIFO producer and the DMA consumer. slave: the capture block.
interface drc_frame_capture_fsm_if #(
  parameter int DVP_DATA_W = 8
);
  logic [DVP_DATA_W+1:0] bwd_pxl_info_dat;
  logic                  bwd_pxl_info_vld;
  logic                  bwd_pxl_info_rdy;
  logic [DVP_DATA_W-1:0] fwd_bt_dat;
  logic                  fwd_bt_eol;
  logic                  fwd_bt_eof;
  logic                  fwd_bt_pad;
  logic                  fwd_bt_vld;
  logic                  fwd_bt_rdy;

  modport master (
    output bwd_pxl_info_dat, bwd_pxl_info_vld, fwd_bt_rdy,
    input  bwd_pxl_info_rdy, fwd_bt_dat, fwd_bt_eol, fwd_bt_eof, fwd_bt_pad, fwd_bt_vld
  );

  modport slave (
    input  bwd_pxl_info_dat, bwd_pxl_info_vld, fwd_bt_rdy,
    output bwd_pxl_info_rdy, fwd_bt_dat, fwd_bt_eol, fwd_bt_eof, fwd_bt_pad, fwd_bt_vld
  );
endinterface

// File: rtl/drc_frame_capture_fsm.sv
// DVP RX capture state machine: aligns to VSYNC, forwards pixel beats to the
// DMA, checks HSYNC/VSYNC placement, pads errored frames to full length and
// keeps frame/error statistics.
module drc_frame_capture_fsm #(
  parameter int                    DVP_DATA_W    = 8,
  parameter int                    BYTES_PER_PXL = 2,
  parameter int                    IMG_DIM_W     = 10,
  parameter int                    FRM_CNT_W     = 8,
  parameter logic [DVP_DATA_W-1:0] PAD_DATA      = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  drc_frame_capture_fsm_if.slave bus,
  input  logic                 cfg_en,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_start,
  output logic                 cfg_start_ack,
  input  logic [FRM_CNT_W-1:0] cfg_frm_num,
  input  logic [IMG_DIM_W-1:0] img_width,
  input  logic [IMG_DIM_W-1:0] img_height,
  output logic [2:0]           cam_rx_state,
  output logic [FRM_CNT_W-1:0] frm_cnt,
  output logic [FRM_CNT_W-1:0] err_cnt,
  output logic                 irq_frm_comp,
  output logic                 irq_frm_err,
  output logic                 irq_seq_done
);

  localparam int BW = (BYTES_PER_PXL > 1) ? $clog2(BYTES_PER_PXL) : 1;
  localparam logic [BW-1:0] B_LIM = BW'(BYTES_PER_PXL - 1);

  typedef enum logic [2:0] {
    S_SLEEP   = 3'd0,
    S_IDLE    = 3'd1,
    S_ALIGN   = 3'd2,
    S_CAPTURE = 3'd3,
    S_ERR_PAD = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        b_cnt_q, b_cnt_d, b_nxt;
  logic [IMG_DIM_W-1:0] w_cnt_q, w_cnt_d, w_nxt;
  logic [IMG_DIM_W-1:0] h_cnt_q, h_cnt_d, h_nxt;
  logic [IMG_DIM_W-1:0] wid_q, wid_d, hgt_q, hgt_d;
  logic [FRM_CNT_W-1:0] rem_q, rem_d, frm_cnt_q, frm_cnt_d, err_cnt_q, err_cnt_d;
  logic                 irq_comp_q, irq_comp_d, irq_err_q, irq_err_d, irq_seq_q, irq_seq_d;

  logic                  vsync, hsync;
  logic [DVP_DATA_W-1:0] pdata;
  logic                  w_last, b_last, first, eol, eof, sync_err, go_start;

  // A zero dimension behaves as one, so its last index is also zero.
  function automatic logic [IMG_DIM_W-1:0] dim_lim(input logic [IMG_DIM_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [FRM_CNT_W-1:0] sat_inc(input logic [FRM_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign vsync = bus.bwd_pxl_info_dat[DVP_DATA_W+1];
  assign hsync = bus.bwd_pxl_info_dat[DVP_DATA_W];
  assign pdata = bus.bwd_pxl_info_dat[DVP_DATA_W-1:0];

  assign b_last   = (b_cnt_q == B_LIM);
  assign w_last   = (w_cnt_q == dim_lim(wid_q));
  assign first    = (b_cnt_q == '0) && (w_cnt_q == '0) && (h_cnt_q == '0);
  assign eol      = b_last && w_last;
  assign eof      = eol && (h_cnt_q == dim_lim(hgt_q));
  assign sync_err = (hsync != ((b_cnt_q == '0) && (w_cnt_q == '0))) || (vsync != first);
  assign go_start = cfg_en && cfg_start && (cfg_mode != 2'd0);

  // Beat/pixel/line counter values after one forward handshake.
  always_comb begin
    b_nxt = b_cnt_q + 1'b1;
    w_nxt = w_cnt_q;
    h_nxt = h_cnt_q;
    if (b_last) begin
      b_nxt = '0;
      w_nxt = w_last ? '0 : w_cnt_q + 1'b1;
      if (w_last) h_nxt = (h_cnt_q == dim_lim(hgt_q)) ? '0 : h_cnt_q + 1'b1;
    end
  end

  // Next-state, counter updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    b_cnt_d   = b_cnt_q;
    w_cnt_d   = w_cnt_q;
    h_cnt_d   = h_cnt_q;
    wid_d     = wid_q;
    hgt_d     = hgt_q;
    rem_d     = rem_q;
    frm_cnt_d = frm_cnt_q;
    err_cnt_d = err_cnt_q;
    irq_comp_d = 1'b0;
    irq_err_d  = 1'b0;
    irq_seq_d  = 1'b0;
    bus.bwd_pxl_info_rdy = 1'b0;
    bus.fwd_bt_vld       = 1'b0;
    bus.fwd_bt_dat       = pdata;
    bus.fwd_bt_pad       = 1'b0;
    cfg_start_ack        = 1'b0;
    unique case (state_q)
      S_SLEEP: begin
        bus.bwd_pxl_info_rdy = 1'b1;
        if (go_start) begin
          state_d       = S_ALIGN;
          wid_d         = img_width;
          hgt_d         = img_height;
          cfg_start_ack = (cfg_mode == 2'd1) || (cfg_mode == 2'd3);
          if (cfg_mode == 2'd3)
            rem_d = (cfg_frm_num == '0) ? FRM_CNT_W'(1) : cfg_frm_num;
        end
      end
      S_ALIGN: begin
        if (!cfg_en) begin
          state_d = S_SLEEP;
        end else if (bus.bwd_pxl_info_vld && vsync) begin
          // Leave the VSYNC beat in the FIFO; CAPTURE forwards it as beat 0.
          b_cnt_d = '0;
          w_cnt_d = '0;
          h_cnt_d = '0;
          state_d = S_CAPTURE;
        end else begin
          bus.bwd_pxl_info_rdy = 1'b1;
        end
      end
      S_CAPTURE: begin
        bus.fwd_bt_vld       = bus.bwd_pxl_info_vld;
        bus.bwd_pxl_info_rdy = bus.fwd_bt_rdy;
        if (bus.bwd_pxl_info_vld && bus.fwd_bt_rdy) begin
          b_cnt_d = b_nxt;
          w_cnt_d = w_nxt;
          h_cnt_d = h_nxt;
          if (sync_err) begin
            irq_err_d = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            state_d   = eof ? S_ALIGN : S_ERR_PAD;
          end else if (eof) begin
            irq_comp_d = 1'b1;
            frm_cnt_d  = frm_cnt_q + 1'b1;
            if (rem_q != '0) rem_d = rem_q - 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_ERR_PAD: begin
        bus.bwd_pxl_info_rdy = 1'b1;
        bus.fwd_bt_vld       = 1'b1;
        bus.fwd_bt_dat       = PAD_DATA;
        bus.fwd_bt_pad       = 1'b1;
        if (bus.fwd_bt_rdy) begin
          b_cnt_d = b_nxt;
          w_cnt_d = w_nxt;
          h_cnt_d = h_nxt;
          if (eof) state_d = S_ALIGN;
        end
      end
      S_IDLE: begin
        if (cfg_en && (((cfg_mode == 2'd1) && cfg_start) || (cfg_mode == 2'd2) ||
                       ((cfg_mode == 2'd3) && (rem_q != '0)))) begin
          cfg_start_ack = (cfg_mode == 2'd1);
          wid_d         = img_width;
          hgt_d         = img_height;
          state_d       = S_CAPTURE;
        end else begin
          irq_seq_d = (cfg_mode == 2'd3) && (rem_q == '0);
          state_d   = S_SLEEP;
        end
      end
      default: state_d = S_SLEEP;
    endcase
  end

  assign bus.fwd_bt_eol = eol && ((state_q == S_CAPTURE) || (state_q == S_ERR_PAD));
  assign bus.fwd_bt_eof = eof && ((state_q == S_CAPTURE) || (state_q == S_ERR_PAD));

  // State, counters, shadows, statistics and registered interrupt pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SLEEP;
      b_cnt_q    <= '0;
      w_cnt_q    <= '0;
      h_cnt_q    <= '0;
      wid_q      <= '0;
      hgt_q      <= '0;
      rem_q      <= '0;
      frm_cnt_q  <= '0;
      err_cnt_q  <= '0;
      irq_comp_q <= 1'b0;
      irq_err_q  <= 1'b0;
      irq_seq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_cnt_q    <= b_cnt_d;
      w_cnt_q    <= w_cnt_d;
      h_cnt_q    <= h_cnt_d;
      wid_q      <= wid_d;
      hgt_q      <= hgt_d;
      rem_q      <= rem_d;
      frm_cnt_q  <= frm_cnt_d;
      err_cnt_q  <= err_cnt_d;
      irq_comp_q <= irq_comp_d;
      irq_err_q  <= irq_err_d;
      irq_seq_q  <= irq_seq_d;
    end
  end

  assign cam_rx_state = state_q;
  assign frm_cnt      = frm_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign irq_frm_comp = irq_comp_q;
  assign irq_frm_err  = irq_err_q;
  assign irq_seq_done = irq_seq_q;

endmodule

// File: tb/tb_drc_frame_capture_fsm.sv
// Directed bench for drc_frame_capture_fsm with a beat scoreboard.
module tb_drc_frame_capture_fsm;

  localparam int         DW  = 8;
  localparam int         BPP = 2;
  localparam int         IW  = 10;
  localparam int         FW  = 8;
  localparam logic [7:0] PAD = 8'hA5;

  logic          clk, rst_n;
  logic          cfg_en, cfg_start, cfg_start_ack;
  logic [1:0]    cfg_mode;
  logic [FW-1:0] cfg_frm_num, frm_cnt, err_cnt;
  logic [IW-1:0] img_width, img_height;
  logic [2:0]    cam_rx_state;
  logic          irq_frm_comp, irq_frm_err, irq_seq_done;

  drc_frame_capture_fsm_if #(.DVP_DATA_W(DW)) bus_if ();

  drc_frame_capture_fsm #(
    .DVP_DATA_W(DW), .BYTES_PER_PXL(BPP), .IMG_DIM_W(IW), .FRM_CNT_W(FW), .PAD_DATA(PAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_start(cfg_start), .cfg_start_ack(cfg_start_ack),
    .cfg_frm_num(cfg_frm_num), .img_width(img_width), .img_height(img_height),
    .cam_rx_state(cam_rx_state), .frm_cnt(frm_cnt), .err_cnt(err_cnt),
    .irq_frm_comp(irq_frm_comp), .irq_frm_err(irq_frm_err), .irq_seq_done(irq_seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  src_q[$];   // {vsync, hsync, data} entries waiting in the "FIFO"
  logic [10:0] exp_q[$];   // {dat, eol, eof, pad} expected on the forward side
  int n_cmp = 0, n_bad = 0;
  int start_pend = 0;
  bit bp_en = 0;
  int n_comp = 0, n_err = 0, n_seq = 0, n_ack = 0, n_sleep = 0, n_idle = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model / DMA ready / start-queue driver.
  initial begin
    logic hs_b, ack_s;
    bus_if.bwd_pxl_info_vld = 1'b0;
    bus_if.bwd_pxl_info_dat = '0;
    bus_if.fwd_bt_rdy       = 1'b1;
    cfg_start               = 1'b0;
    forever begin
      @(negedge clk);
      hs_b  = bus_if.bwd_pxl_info_vld & bus_if.bwd_pxl_info_rdy;
      ack_s = cfg_start_ack;
      @(posedge clk);
      #1;
      if (hs_b && src_q.size() != 0) void'(src_q.pop_front());
      if (ack_s && start_pend != 0) start_pend--;
      bus_if.bwd_pxl_info_vld = (src_q.size() != 0);
      if (src_q.size() != 0) bus_if.bwd_pxl_info_dat = src_q[0];
      bus_if.fwd_bt_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_start = (start_pend != 0);
    end
  end

  // Scoreboard consumer and event counters.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (irq_frm_comp) n_comp++;
        if (irq_frm_err) n_err++;
        if (irq_seq_done) n_seq++;
        if (cfg_start_ack) n_ack++;
        if (cam_rx_state == 3'd0) n_sleep++;
        if (cam_rx_state == 3'd1) n_idle++;
        if (bus_if.fwd_bt_vld && bus_if.fwd_bt_rdy) begin
          chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", {bus_if.fwd_bt_dat, bus_if.fwd_bt_eol, bus_if.fwd_bt_eof, bus_if.fwd_bt_pad}, e);
          end
        end
      end
    end
  end

  // Queue one frame; bad>=0 corrupts that beat (hsync or vsync flipped).
  task automatic push_frame(input int w, input int h, input int bad, input bit flip_vs);
    int wp, hp, bpl, n;
    logic vs, hs, is_pad;
    logic [7:0] d;
    wp  = (w == 0) ? 1 : w;
    hp  = (h == 0) ? 1 : h;
    bpl = BPP * wp;
    n   = bpl * hp;
    for (int k = 0; k < n; k++) begin
      vs = (k == 0);
      hs = ((k % bpl) == 0);
      d  = 8'($urandom_range(0, 255));
      if (k == bad) begin
        if (flip_vs) vs = ~vs;
        else hs = ~hs;
      end
      is_pad = (bad >= 0) && (k > bad);
      src_q.push_back({vs, hs, d});
      exp_q.push_back({is_pad ? PAD : d, (k % bpl) == (bpl - 1), k == (n - 1), is_pad});
    end
  endtask

  task automatic push_junk(input int n);
    for (int k = 0; k < n; k++) src_q.push_back({1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 64'(src_q.size() + exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    int n = 0;
    @(negedge clk);
    while (cam_rx_state != st && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cam_rx_state, st);
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    int s_ack, s_sleep, s_idle, s_err, s_comp, n;
    rst_n = 1'b0; cfg_en = 1'b0; cfg_mode = 2'd0; cfg_frm_num = '0;
    img_width = 10'd4; img_height = 10'd2;
    repeat (3) @(posedge clk);
    sample();
    chk("rst_state", cam_rx_state, 3'd0);
    chk("rst_frm_cnt", frm_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_bwd_rdy", bus_if.bwd_pxl_info_rdy, 1);
    chk("rst_fwd_vld", bus_if.fwd_bt_vld, 0);
    chk("rst_ack", cfg_start_ack, 0);
    chk("rst_irqs", {irq_frm_comp, irq_frm_err, irq_seq_done}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single-shot clean 4x2 frame.
    cfg_en = 1'b1; cfg_mode = 2'd1; start_pend = 1;
    wait_state("ss_align", 3'd2);
    push_frame(4, 2, -1, 1'b0);
    wait_drain("ss_drain");
    sample();
    chk("ss_frm_cnt", frm_cnt, 1);
    chk("ss_irq_comp", n_comp, 1);
    chk("ss_ack", n_ack, 1);
    chk("ss_state", cam_rx_state, 3'd0);

    // Misaligned HSYNC on beat 5, then recapture after junk.
    start_pend = 1;
    wait_state("mis_align", 3'd2);
    push_frame(4, 2, 4, 1'b0);
    wait_drain("mis_drain");
    sample();
    chk("mis_err_cnt", err_cnt, 1);
    chk("mis_irq_err", n_err, 1);
    chk("mis_state_align", cam_rx_state, 3'd2);
    @(posedge clk); #2;
    push_junk(3);
    push_frame(4, 2, -1, 1'b0);
    wait_drain("mis_recap_drain");
    sample();
    chk("mis_frm_cnt", frm_cnt, 2);
    chk("mis_state_sleep", cam_rx_state, 3'd0);
    chk("mis_ack", n_ack, 2);

    // Multi-shot of 3 with the second frame corrupted.
    @(posedge clk); #2;
    cfg_mode = 2'd3; cfg_frm_num = 8'd3; start_pend = 1;
    wait_state("ms_align", 3'd2);
    push_frame(4, 2, -1, 1'b0);
    wait_drain("ms_f1");
    push_frame(4, 2, 8, 1'b0);
    wait_drain("ms_f2");
    push_frame(4, 2, -1, 1'b0);
    wait_drain("ms_f3");
    push_frame(4, 2, -1, 1'b0);
    wait_drain("ms_f4");
    repeat (2) @(posedge clk);
    sample();
    chk("ms_frm_cnt", frm_cnt, 5);
    chk("ms_err_cnt", err_cnt, 2);
    chk("ms_seq_done", n_seq, 1);
    chk("ms_state", cam_rx_state, 3'd0);
    chk("ms_ack", n_ack, 3);

    // Stream with random DMA backpressure.
    @(posedge clk); #2;
    cfg_mode = 2'd2; start_pend = 1;
    wait_state("st_align", 3'd2);
    s_ack = n_ack; s_sleep = n_sleep; s_idle = n_idle;
    bp_en = 1;
    for (int f = 0; f < 3; f++) push_frame(4, 2, -1, 1'b0);
    wait_drain("st_drain");
    bp_en = 0;
    sample();
    chk("st_frm_cnt", frm_cnt, 8);
    chk("st_no_ack", n_ack, s_ack);
    chk("st_no_sleep", n_sleep, s_sleep);
    chk("st_idle_visits", n_idle, s_idle + 3);
    chk("st_state", cam_rx_state, 3'd3);

    // Drop cfg_en mid-frame: frame completes, then SLEEP.
    @(posedge clk); #2;
    push_frame(4, 2, -1, 1'b0);
    n = 0;
    while (exp_q.size() > 8 && n < 200) begin
      @(posedge clk); n++;
    end
    #2;
    cfg_en = 1'b0;
    start_pend = 0;
    wait_drain("dis_drain");
    sample();
    chk("dis_frm_cnt", frm_cnt, 9);
    chk("dis_state", cam_rx_state, 3'd0);

    // 300 errored frames: err_cnt saturates.
    @(posedge clk); #2;
    cfg_en = 1'b1; start_pend = 1;
    s_err = n_err; s_comp = n_comp;
    wait_state("sat_align", 3'd2);
    for (int f = 0; f < 300; f++) begin
      push_frame(4, 2, 2, 1'b1);
      wait_drain("sat_drain");
    end
    sample();
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_irq_err", n_err, s_err + 300);
    chk("sat_no_comp", n_comp, s_comp);
    @(posedge clk); #2;
    cfg_en = 1'b0; start_pend = 0;
    repeat (3) @(posedge clk);
    sample();
    chk("sat_state", cam_rx_state, 3'd0);

    // Reset during CAPTURE.
    @(posedge clk); #2;
    cfg_en = 1'b1; cfg_mode = 2'd1; start_pend = 1;
    wait_state("rr_align", 3'd2);
    push_frame(4, 2, -1, 1'b0);
    n = 0;
    while (exp_q.size() > 10 && n < 200) begin
      @(posedge clk); n++;
    end
    sample();
    chk("rr_pre_state", cam_rx_state, 3'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    src_q.delete(); exp_q.delete(); start_pend = 0;
    repeat (2) @(posedge clk);
    sample();
    chk("rr_state", cam_rx_state, 3'd0);
    chk("rr_frm_cnt", frm_cnt, 0);
    chk("rr_err_cnt", err_cnt, 0);
    chk("rr_bwd_rdy", bus_if.bwd_pxl_info_rdy, 1);
    chk("rr_fwd_vld", bus_if.fwd_bt_vld, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Width 0 behaves as width 1.
    img_width = 10'd0; img_height = 10'd2; start_pend = 1;
    wait_state("w0_align", 3'd2);
    push_frame(0, 2, -1, 1'b0);
    wait_drain("w0_drain");
    sample();
    chk("w0_frm_cnt", frm_cnt, 1);
    chk("w0_state", cam_rx_state, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drc_frame_capture_fsm.md
# drc_frame_capture_fsm

Parametrised successor to the DVP RX capture state machine. It sits between the DVP pixel FIFO (`{VSYNC, HSYNC, DATA}` entries) and the DMA byte stream. It supports multi-byte pixels, a multi-shot mode and VSYNC plus HSYNC alignment checking. It tags line and frame ends, pads errored frames to full length, and keeps frame and error statistics.

## Interface
- `DVP_DATA_W`, 8, DVP bus width (bits per byte beat)
- `BYTES_PER_PXL`, 2, beats per pixel (1..4)
- `IMG_DIM_W`, 10, width of the image-dimension counters
- `FRM_CNT_W`, 8, width of the frame counter, the error counter and `cfg_frm_num`
- `PAD_DATA`, 0, data value driven on padding beats
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `bwd_pxl_info_dat`  in  DVP_DATA_W+2  `{vsync, hsync, data}`
- `bwd_pxl_info_vld`  in  1 / `bwd_pxl_info_rdy`  out  1  FIFO-side handshake
- `fwd_bt_dat`  out  DVP_DATA_W  byte to the DMA
- `fwd_bt_eol`  out  1  last beat of a line
- `fwd_bt_eof`  out  1  last beat of a frame
- `fwd_bt_pad`  out  1  beat is padding
- `fwd_bt_vld`  out  1 / `fwd_bt_rdy`  in  1  DMA-side handshake
- `cfg_en`  in  1  RX enable
- `cfg_mode`  in  2  0 sleep, 1 single-shot, 2 stream, 3 multi-shot
- `cfg_start`  in  1  start request (queue not empty)
- `cfg_start_ack`  out  1  pops the start queue
- `cfg_frm_num`  in  FRM_CNT_W  frames per multi-shot sequence (0 is treated as 1)
- `img_width`, `img_height`  in  IMG_DIM_W each  pixels per line and lines per frame (0 is treated as 1)
- `cam_rx_state`  out  3  current state
- `frm_cnt`  out  FRM_CNT_W  completed-frame count, wraps
- `err_cnt`  out  FRM_CNT_W  errored-frame count, saturates
- `irq_frm_comp`, `irq_frm_err`, `irq_seq_done`  out  1 each  one-cycle pulses

## Operation
- Counters:
  - `b_cnt` counts beats within a pixel (0..BYTES_PER_PXL-1).
  - `w_cnt` and `h_cnt` count pixels and lines.
  - Each counter advances on a forward handshake and wraps at its limit.
  - The limits come from shadow copies of `img_width` and `img_height`. The shadows are latched on SLEEP→ALIGN and on IDLE→CAPTURE.
- Flags:
  - `first` = all counters are 0.
  - `eol` = last beat of the last pixel of a line.
  - `eof` = `eol` and `h_cnt` is at its limit.
- States: SLEEP=0, IDLE=1, ALIGN=2, CAPTURE=3, ERR_PAD=4.
- SLEEP:
  - `bwd_pxl_info_rdy`=1 (drop all input).
  - If `cfg_en` & `cfg_start` & mode≠0: go to ALIGN.
  - In single-shot and multi-shot, assert `cfg_start_ack` in the same cycle. Stream does not pop.
  - Multi-shot loads `remaining` = max(`cfg_frm_num`, 1).
- ALIGN:
  - If `cfg_en`=0: go to SLEEP.
  - Else `rdy`=1 (skip input) until `vld` & `vsync`. On that cycle, `rdy`=0, clear the counters and go to CAPTURE. The VSYNC beat is not popped.
- CAPTURE:
  - Pass-through: `fwd_bt_vld`=`bwd_pxl_info_vld`, `bwd_pxl_info_rdy`=`fwd_bt_rdy`, `fwd_bt_dat`=data, `pad`=0.
  - On each handshake, check two conditions. An error is either one failing:
    - `hsync` must equal (`b_cnt`==0 & `w_cnt`==0).
    - `vsync` must equal `first`.
  - The erroneous beat is still forwarded and counted.
  - Error, not `eof`: go to ERR_PAD.
  - Error on `eof`: go to ALIGN.
  - Either error case: pulse `irq_frm_err` and increment `err_cnt` (saturating).
  - Clean `eof`: go to IDLE, pulse `irq_frm_comp`, increment `frm_cnt`, decrement `remaining`.
- ERR_PAD:
  - `rdy`=1 (drain input), `fwd_bt_vld`=1, `dat`=`PAD_DATA`, `pad`=1.
  - Counters advance on forward handshakes; `eol`/`eof` remain correct.
  - The handshake with `eof` goes to ALIGN.
  - Errored frames do not count toward `frm_cnt` or `remaining`.
- IDLE (one cycle):
  - Continue to CAPTURE when `cfg_en` & mode≠0 and one of:
    - single-shot with `cfg_start` (pop it);
    - stream;
    - multi-shot with `remaining`≠0.
  - Otherwise go to SLEEP. Pulse `irq_seq_done` if the mode is multi-shot and `remaining`=0.
- `cfg_mode` is evaluated only in SLEEP and IDLE. Changes made mid-frame take effect at the frame boundary.
- Deasserting `cfg_en` mid-frame does not abort. The frame (or its padding) completes, then the block goes to SLEEP via IDLE or ALIGN.

## Timing
- Reset values:
  - State SLEEP; all counters, `remaining`, `frm_cnt`, `err_cnt` = 0; IRQs = 0.
  - Combinational outputs: `bwd_pxl_info_rdy`=1, `fwd_bt_vld`=0, `cfg_start_ack`=0.
- CAPTURE data path has zero latency (combinational pass-through).
- `fwd_bt_eol`, `fwd_bt_eof`, `fwd_bt_pad` are combinational from state and counters, valid with `fwd_bt_vld`.
- IRQs are registered: each pulses for exactly one cycle, the cycle after the causing handshake.
- Forward payload is held stable while `vld` & ~`rdy`, except in pass-through, where the FIFO guarantees stability.
- Counter arithmetic is unsigned. Limit compare is `cnt` == max(dim,1)-1, so a dimension of 0 is treated as 1.
- Reset asserted mid-frame: immediate return to reset values; no flush.

## Test plan
- Single-shot:
  - Stimulus: `BYTES_PER_PXL`=2, 4x2 image, clean frame.
  - Response: 16 beats forwarded; `eol` on beats 8 and 16; `eof` on beat 16; `irq_frm_comp` one pulse; `frm_cnt`=1; `cfg_start_ack` one pulse; return to SLEEP.
- Misaligned HSYNC:
  - Stimulus: HSYNC on beat 5 of the same frame.
  - Response: `irq_frm_err`; beats 6..16 have `pad`=1 and `dat`=`PAD_DATA`, with `eof` on beat 16; `err_cnt`=1; ALIGN then recapture on the next VSYNC.
- Multi-shot:
  - Stimulus: `cfg_frm_num`=3, the second frame corrupted.
  - Response: four frames captured; `frm_cnt`=3; `err_cnt`=1; a single `irq_seq_done`; SLEEP.
- Stream backpressure:
  - Stimulus: stream mode with `fwd_bt_rdy` toggled randomly.
  - Response: no beats lost or duplicated; `cfg_start_ack` never asserted; the next frame continues via IDLE without a SLEEP visit.
- Mid-frame disable and error saturation:
  - Stimulus: `cfg_en` dropped mid-frame; then 300 errored frames with `FRM_CNT_W`=8.
  - Response: the current frame completes, then SLEEP; `err_cnt` holds at 255.
- Reset and dimension 0:
  - Stimulus: `rst_n` pulsed during CAPTURE; then `img_width`=0.
  - Response: reset values seen; the 0 width behaves as 1 (`eol` on every pixel's last beat).
